// File: rtl/write_back_pipe.sv
// write_back_pipe: write-back stage with a one-entry output
// register plus one skid entry, so in_ready can come from a flop.
// Params: WIDTH (datapath bits, multiple of 8, >=16),
//   RADDR_W (register address bits).
// Ports:
//   wb_clk, wb_rst     clock, async active-high reset
//   in_valid/in_ready  upstream handshake
//   read_data          load data
//   alu_result         ALU value, also the load address
//   pc_in              PC (link value is pc_in+4)
//   wb_sel             00/11 ALU, 01 memory, 10 link
//   ld_size/ld_signed  load width and extension
//   rd_in/reg_write_in destination and write enable
//   out_stall          register-file port busy
//   out_valid, reg_write_out, rd_out, write_data,
//   pc_out, pc_write   output entry (pc_write when rd is all-ones)
// Option: define WB_SUBWORD_EN to extract and extend byte and
//   half loads; otherwise memory data passes through unmodified.
module write_back_pipe #(
  parameter int WIDTH   = 32,
  parameter int RADDR_W = 4
) (
  input  logic               wb_clk,
  input  logic               wb_rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   read_data,
  input  logic [WIDTH-1:0]   alu_result,
  input  logic [WIDTH-1:0]   pc_in,
  input  logic [1:0]         wb_sel,
  input  logic [1:0]         ld_size,
  input  logic               ld_signed,
  input  logic [RADDR_W-1:0] rd_in,
  input  logic               reg_write_in,
  input  logic               out_stall,
  output logic               out_valid,
  output logic               reg_write_out,
  output logic [RADDR_W-1:0] rd_out,
  output logic [WIDTH-1:0]   write_data,
  output logic [WIDTH-1:0]   pc_out,
  output logic               pc_write
);

  typedef struct packed {
    logic               rw;
    logic [RADDR_W-1:0] rd;
    logic [WIDTH-1:0]   data;
    logic [WIDTH-1:0]   pc;
  } wb_entry_t;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } state_t;

  state_t    state;
  state_t    state_nx;
  wb_entry_t out_q;
  wb_entry_t skid_q;
  wb_entry_t in_e;
  logic      ready_q;
  logic      accept;
  logic      consume;
  logic      ld_out;
  logic      ld_skid;
  logic      ld_promote;

  logic [WIDTH-1:0] link;
  logic [WIDTH-1:0] ld_val;
  logic [WIDTH-1:0] wdata;
  logic             sel_mem;
  logic             sel_link;

  // ---- value selection ----
  assign link     = pc_in + WIDTH'(4);
  assign sel_mem  = (wb_sel == 2'b01);
  assign sel_link = (wb_sel == 2'b10);

`ifdef WB_SUBWORD_EN
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic        is_byte;
  logic        is_half;

  // Lane picked by the low address bits of the load.
  assign ld_byte =
    8'(read_data >> {alu_result[1:0], 3'b000});
  assign ld_half =
    16'(read_data >> {alu_result[1], 4'b0000});
  assign is_byte = (ld_size == 2'b10);
  assign is_half = (ld_size == 2'b01);

  always_comb begin
    ld_val = read_data;
    unique case (1'b1)
      is_byte: begin
        ld_val = {WIDTH{ld_signed & ld_byte[7]}};
        ld_val[7:0] = ld_byte;
      end
      is_half: begin
        ld_val = {WIDTH{ld_signed & ld_half[15]}};
        ld_val[15:0] = ld_half;
      end
      default: ld_val = read_data;
    endcase
  end
`else
  logic unused_ld;
  assign unused_ld = ^{ld_size, ld_signed};
  assign ld_val    = read_data;
`endif

  always_comb begin
    wdata = alu_result;
    unique case (1'b1)
      sel_mem:  wdata = ld_val;
      sel_link: wdata = link;
      default:  wdata = alu_result;
    endcase
  end

  assign in_e = '{
    rw:   reg_write_in,
    rd:   rd_in,
    data: wdata,
    pc:   pc_in
  };

  // ---- handshake ----
  assign accept  = in_valid & ready_q;
  assign consume = (state != EMPTY) & ~out_stall;

  always_comb begin
    state_nx   = state;
    ld_out     = 1'b0;
    ld_skid    = 1'b0;
    ld_promote = 1'b0;
    unique case (state)
      EMPTY: begin
        if (accept) begin
          state_nx = ONE;
          ld_out   = 1'b1;
        end
      end
      ONE: begin
        if (consume && accept) begin
          ld_out = 1'b1;
        end else if (consume) begin
          state_nx = EMPTY;
        end else if (accept) begin
          state_nx = FULL;
          ld_skid  = 1'b1;
        end
      end
      FULL: begin
        // ready_q is low here, so nothing new arrives
        if (consume) begin
          state_nx   = ONE;
          ld_promote = 1'b1;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state   <= EMPTY;
      ready_q <= 1'b1;
    end else begin
      state   <= state_nx;
      // registered copy of "skid is free"
      ready_q <= (state_nx != FULL);
    end
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      out_q  <= '0;
      skid_q <= '0;
    end else begin
      if (ld_out) begin
        out_q <= in_e;
      end else if (ld_promote) begin
        out_q <= skid_q;
      end
      if (ld_skid) begin
        skid_q <= in_e;
      end
    end
  end

  // ---- outputs ----
  assign in_ready      = ready_q;
  assign out_valid     = (state != EMPTY);
  assign reg_write_out = out_valid & out_q.rw;
  assign rd_out        = out_q.rd;
  assign write_data    = out_q.data;
  assign pc_out        = out_q.pc;
  assign pc_write      = reg_write_out & (&out_q.rd);

endmodule

// File: tb/tb_write_back_pipe.sv
// tb_write_back_pipe: table vectors, directed stall/reset
// sequences and random traffic against a queue model.
module tb_write_back_pipe;

  localparam int W  = 32;
  localparam int RW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  read_data = '0;
  logic [W-1:0]  alu_result = '0;
  logic [W-1:0]  pc_in = '0;
  logic [1:0]    wb_sel = '0;
  logic [1:0]    ld_size = '0;
  logic          ld_signed = 1'b0;
  logic [RW-1:0] rd_in = '0;
  logic          reg_write_in = 1'b0;
  logic          out_stall = 1'b0;
  logic          out_valid;
  logic          reg_write_out;
  logic [RW-1:0] rd_out;
  logic [W-1:0]  write_data;
  logic [W-1:0]  pc_out;
  logic          pc_write;

  always #5 clk = ~clk;

  write_back_pipe #(
    .WIDTH   (W),
    .RADDR_W (RW)
  ) dut (
    .wb_clk        (clk),
    .wb_rst        (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .read_data     (read_data),
    .alu_result    (alu_result),
    .pc_in         (pc_in),
    .wb_sel        (wb_sel),
    .ld_size       (ld_size),
    .ld_signed     (ld_signed),
    .rd_in         (rd_in),
    .reg_write_in  (reg_write_in),
    .out_stall     (out_stall),
    .out_valid     (out_valid),
    .reg_write_out (reg_write_out),
    .rd_out        (rd_out),
    .write_data    (write_data),
    .pc_out        (pc_out),
    .pc_write      (pc_write)
  );

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Reference write value from the selection/extension rules.
  function automatic logic [31:0] ref_wd(
    input logic [1:0]  sel,
    input logic [1:0]  size,
    input logic        sgn,
    input logic [31:0] rdata,
    input logic [31:0] alu,
    input logic [31:0] pc
  );
    int unsigned v;
    int unsigned div;
    if (sel == 2'd2) return pc + 32'd4;
    if (sel != 2'd1) return alu;
    v = rdata;
`ifdef WB_SUBWORD_EN
    if (size == 2'd2) begin
      div = 1 << (8 * alu[1:0]);
      v = (rdata / div) % 256;
      if (sgn && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      div = 1 << (16 * alu[1]);
      v = (rdata / div) % 65536;
      if (sgn && v >= 32768) v = v + 32'hFFFF_0000;
    end
`else
    div = {30'd0, size} + {31'd0, sgn};
    if (div > 32'd9) v = 0;
`endif
    return v;
  endfunction

  typedef struct {
    logic [1:0]  sel;
    logic [1:0]  size;
    logic        sgn;
    logic [31:0] rdata;
    logic [31:0] alu;
    logic [31:0] pc;
    logic [3:0]  rd;
    logic        rw;
    logic [31:0] wd;
    logic        pcw;
  } vec_t;

  typedef struct {
    logic [31:0] wd;
    logic [3:0]  rd;
    logic [31:0] pc;
    logic        rw;
  } exp_t;

`ifdef WB_SUBWORD_EN
  localparam logic [31:0] E_B2S = 32'hFFFF_FFFF;
  localparam logic [31:0] E_H1U = 32'h0000_80FF;
  localparam logic [31:0] E_B1S = 32'h0000_007F;
  localparam logic [31:0] E_H1S = 32'hFFFF_80FF;
  localparam logic [31:0] E_B0S = 32'h0000_0001;
`else
  localparam logic [31:0] E_B2S = 32'h80FF_7F01;
  localparam logic [31:0] E_H1U = 32'h80FF_7F01;
  localparam logic [31:0] E_B1S = 32'h80FF_7F01;
  localparam logic [31:0] E_H1S = 32'h80FF_7F01;
  localparam logic [31:0] E_B0S = 32'h80FF_7F01;
`endif

  localparam logic [31:0] MD = 32'h80FF_7F01;

  vec_t vecs[13];
  exp_t q[$];

  task automatic offer(input logic [31:0] a,
                       input logic [3:0] r);
    in_valid     = 1'b1;
    wb_sel       = 2'b00;
    alu_result   = a;
    pc_in        = a + 32'h100;
    rd_in        = r;
    reg_write_in = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{2'd0, 2'd0, 1'b0, 32'h0, 32'h0000_1234,
                 32'h100, 4'd3, 1'b1, 32'h0000_1234, 1'b0};
    vecs[1]  = '{2'd2, 2'd0, 1'b0, 32'h0, 32'h5,
                 32'hFFFF_FFFC, 4'd5, 1'b1, 32'h0, 1'b0};
    vecs[2]  = '{2'd1, 2'd2, 1'b1, MD, 32'h2,
                 32'h0, 4'd7, 1'b1, E_B2S, 1'b0};
    vecs[3]  = '{2'd1, 2'd1, 1'b0, MD, 32'h2,
                 32'h4, 4'd8, 1'b1, E_H1U, 1'b0};
    vecs[4]  = '{2'd0, 2'd0, 1'b0, 32'h0, 32'hDEAD_0000,
                 32'h8, 4'd15, 1'b1, 32'hDEAD_0000, 1'b1};
    vecs[5]  = '{2'd3, 2'd0, 1'b0, 32'h1, 32'h0000_55AA,
                 32'hC, 4'd1, 1'b1, 32'h0000_55AA, 1'b0};
    vecs[6]  = '{2'd1, 2'd2, 1'b1, MD, 32'h1,
                 32'h10, 4'd2, 1'b1, E_B1S, 1'b0};
    vecs[7]  = '{2'd1, 2'd1, 1'b1, MD, 32'h2,
                 32'h14, 4'd4, 1'b1, E_H1S, 1'b0};
    vecs[8]  = '{2'd1, 2'd3, 1'b1, MD, 32'h2,
                 32'h18, 4'd6, 1'b1, MD, 1'b0};
    vecs[9]  = '{2'd1, 2'd0, 1'b0, MD, 32'h3,
                 32'h1C, 4'd9, 1'b1, MD, 1'b0};
    vecs[10] = '{2'd0, 2'd0, 1'b0, 32'h0, 32'h77,
                 32'h20, 4'd15, 1'b0, 32'h77, 1'b0};
    vecs[11] = '{2'd1, 2'd2, 1'b1, MD, 32'h0,
                 32'h24, 4'd10, 1'b1, E_B0S, 1'b0};
    vecs[12] = '{2'd2, 2'd0, 1'b0, 32'h0, 32'h9,
                 32'h1000, 4'd15, 1'b1, 32'h1004, 1'b1};

    // ---- reset ----
    #1 rst = 1'b1;
    #2;
    chk("rst out_valid", out_valid, 0);
    chk("rst in_ready", in_ready, 1);
    repeat (2) @(negedge clk);
    chk("rst rwo", reg_write_out, 0);
    chk("rst pc_write", pc_write, 0);
    chk("rst rd_out", rd_out, 0);
    chk("rst write_data", write_data, 0);
    chk("rst pc_out", pc_out, 0);
    rst = 1'b0;

    // ---- table vectors, one entry each ----
    for (int i = 0; i < 13; i++) begin
      @(negedge clk);
      wb_sel       = vecs[i].sel;
      ld_size      = vecs[i].size;
      ld_signed    = vecs[i].sgn;
      read_data    = vecs[i].rdata;
      alu_result   = vecs[i].alu;
      pc_in        = vecs[i].pc;
      rd_in        = vecs[i].rd;
      reg_write_in = vecs[i].rw;
      in_valid     = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      chk($sformatf("v%0d out_valid", i), out_valid, 1);
      chk($sformatf("v%0d write_data", i), write_data,
          vecs[i].wd);
      chk($sformatf("v%0d rd_out", i), rd_out, vecs[i].rd);
      chk($sformatf("v%0d pc_out", i), pc_out, vecs[i].pc);
      chk($sformatf("v%0d rwo", i), reg_write_out, vecs[i].rw);
      chk($sformatf("v%0d pc_write", i), pc_write,
          vecs[i].pcw);
      @(negedge clk);
      chk($sformatf("v%0d empty", i), out_valid, 0);
      chk($sformatf("v%0d rwo off", i), reg_write_out, 0);
    end

    // ---- stall with A, B, C ----
    @(negedge clk);
    out_stall = 1'b1;
    offer(32'hA, 4'd1);
    @(negedge clk);
    chk("st A valid", out_valid, 1);
    chk("st A data", write_data, 32'hA);
    chk("st A ready", in_ready, 1);
    offer(32'hB, 4'd2);
    @(negedge clk);
    chk("st A held", write_data, 32'hA);
    chk("st full ready", in_ready, 0);
    offer(32'hC, 4'd3);
    @(negedge clk);
    chk("st A still", write_data, 32'hA);
    chk("st A rd", rd_out, 1);
    chk("st C blocked", in_ready, 0);
    out_stall = 1'b0;
    @(negedge clk);
    chk("st B out", write_data, 32'hB);
    chk("st B rd", rd_out, 2);
    chk("st ready back", in_ready, 1);
    @(negedge clk);
    chk("st C out", write_data, 32'hC);
    chk("st C valid", out_valid, 1);
    in_valid = 1'b0;
    @(negedge clk);
    chk("st drained", out_valid, 0);
    chk("st drain ready", in_ready, 1);

    // ---- reset while FULL ----
    out_stall = 1'b1;
    offer(32'h11, 4'd15);
    @(negedge clk);
    offer(32'h22, 4'd15);
    @(negedge clk);
    in_valid = 1'b0;
    chk("rf full ready", in_ready, 0);
    chk("rf rwo", reg_write_out, 1);
    chk("rf pc_write", pc_write, 1);
    rst = 1'b1;
    #1;
    chk("rf out_valid", out_valid, 0);
    chk("rf in_ready", in_ready, 1);
    chk("rf rwo clr", reg_write_out, 0);
    chk("rf pcw clr", pc_write, 0);
    chk("rf data clr", write_data, 0);
    chk("rf rd clr", rd_out, 0);
    chk("rf pc clr", pc_out, 0);
    @(negedge clk);
    rst = 1'b0;
    out_stall = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      chk("rf post rwo", reg_write_out, 0);
      chk("rf post valid", out_valid, 0);
    end

    // ---- random traffic vs queue model ----
    for (int c = 0; c < 3000; c++) begin
      logic cons;
      logic acc;
      exp_t e;
      @(negedge clk);
      chk("rnd out_valid", out_valid, q.size() > 0);
      chk("rnd in_ready", in_ready, q.size() < 2);
      if (q.size() > 0) begin
        chk("rnd write_data", write_data, q[0].wd);
        chk("rnd rd_out", rd_out, q[0].rd);
        chk("rnd pc_out", pc_out, q[0].pc);
        chk("rnd rwo", reg_write_out, q[0].rw);
        chk("rnd pc_write", pc_write,
            q[0].rw && (q[0].rd == 4'hF));
      end else begin
        chk("rnd idle rwo", reg_write_out, 0);
      end
      in_valid     = ($urandom_range(3) != 0);
      out_stall    = ($urandom_range(2) == 0);
      wb_sel       = 2'($urandom);
      ld_size      = 2'($urandom);
      ld_signed    = 1'($urandom);
      read_data    = $urandom;
      alu_result   = $urandom;
      pc_in        = ($urandom_range(7) == 0) ?
                     32'hFFFF_FFFC : $urandom;
      rd_in        = 4'($urandom);
      reg_write_in = 1'($urandom);
      cons = (q.size() > 0) && !out_stall;
      acc  = in_valid && (q.size() < 2);
      if (cons) void'(q.pop_front());
      if (acc) begin
        e.wd = ref_wd(wb_sel, ld_size, ld_signed,
                      read_data, alu_result, pc_in);
        e.rd = rd_in;
        e.pc = pc_in;
        e.rw = reg_write_in;
        q.push_back(e);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
